// File: rtl/cim_host_pkg.sv
// Shared types and constants for the SRAM_CIM host sequencer.
// The CAL phase lengths here fix the 12-cycle calibration schedule.
package cim_host_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        OP_WRITE    = 2'd0,
        OP_WRITEBUF = 2'd1,
        OP_READ     = 2'd2,
        OP_CAL      = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_S_SET,
        ST_C_W0,
        ST_C_IN0,
        ST_C_G0,
        ST_C_W1,
        ST_C_IN1,
        ST_C_G1,
        ST_VFY,
        ST_RSP
    } state_e;

    localparam int LEN_S_SET = 2;
    localparam int LEN_C_W0  = 1;
    localparam int LEN_C_IN0 = 2;
    localparam int LEN_C_G0  = 2;
    localparam int LEN_C_W1  = 1;
    localparam int LEN_C_IN1 = 2;
    localparam int LEN_C_G1  = 2;

    typedef struct packed {
        logic set;
        logic comp;
        logic model;
        logic wait_;
        logic inbit;
    } cal_pins_t;

    // Calibration pin pattern for each phase; every non-CAL state drives all zeros.
    function automatic cal_pins_t cal_pins(state_e s);
        cal_pins_t p;
        p = '0;
        case (s)
            ST_S_SET: p.set = 1'b1;
            ST_C_W0:  begin p.comp = 1'b1; p.wait_ = 1'b1; end
            ST_C_IN0: begin p.comp = 1'b1; p.wait_ = 1'b1; p.inbit = 1'b1; end
            ST_C_G0:  p.comp = 1'b1;
            ST_C_W1:  begin p.comp = 1'b1; p.model = 1'b1; p.wait_ = 1'b1; end
            ST_C_IN1: begin p.comp = 1'b1; p.model = 1'b1; p.wait_ = 1'b1; p.inbit = 1'b1; end
            ST_C_G1:  begin p.comp = 1'b1; p.model = 1'b1; end
            default:  p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/cim_host_ctrl.sv
// Host-side sequencer expanding valid/ready commands into SRAM_CIM pin sequences.
// Optional write-verify readback is enabled with `define CIM_HOST_WRVERIFY_EN.
module cim_host_ctrl
    import cim_host_pkg::*;
#(
    parameter int WR_CYCLES = 21,
    parameter int RD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] cim_a,
    output logic [DATA_W-1:0] cim_d,
    input  logic [DATA_W-1:0] cim_q,
    output logic              cim_wrt,
    output logic              cim_wrtbuf,
    output logic              cim_read,
    output logic              cim_set,
    output logic              cim_comp,
    output logic              cim_model,
    output logic              cim_inbit,
    output logic              cim_wait_
);

    localparam int MAX_CYC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    state_e          state, state_next;
    op_e             op_q, op_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            accept;
    logic            capture;
    cal_pins_t       cal_next;

    assign cmd_ready = (state == ST_IDLE) && !rsp_valid;
    assign accept    = cmd_valid && cmd_ready;

    // Counter value loaded on entry to a state: its length minus one, so zero marks the last cycle.
    function automatic logic [CW-1:0] entry_load(state_e s);
        case (s)
            ST_WR:          return CW'(WR_CYCLES - 1);
            ST_RD, ST_VFY:  return CW'(RD_CYCLES - 1);
            ST_S_SET:       return CW'(LEN_S_SET - 1);
            ST_C_W0:        return CW'(LEN_C_W0 - 1);
            ST_C_IN0:       return CW'(LEN_C_IN0 - 1);
            ST_C_G0:        return CW'(LEN_C_G0 - 1);
            ST_C_W1:        return CW'(LEN_C_W1 - 1);
            ST_C_IN1:       return CW'(LEN_C_IN1 - 1);
            ST_C_G1:        return CW'(LEN_C_G1 - 1);
            default:        return '0;
        endcase
    endfunction

    always_comb begin
        state_next = state;
        op_next    = op_q;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    op_next = op_e'(cmd_op);
                    case (op_e'(cmd_op))
                        OP_WRITE, OP_WRITEBUF: state_next = ST_WR;
                        OP_READ:               state_next = ST_RD;
                        default:               state_next = ST_S_SET;
                    endcase
                end
            end
            ST_WR: begin
                if (cnt == '0) begin
`ifdef CIM_HOST_WRVERIFY_EN
                    state_next = (op_q == OP_WRITE) ? ST_VFY : ST_IDLE;
`else
                    state_next = ST_IDLE;
`endif
                end
            end
            ST_RD:    if (cnt == '0) state_next = ST_RSP;
`ifdef CIM_HOST_WRVERIFY_EN
            ST_VFY:   if (cnt == '0) state_next = ST_RSP;
`endif
            ST_S_SET: if (cnt == '0) state_next = ST_C_W0;
            ST_C_W0:  if (cnt == '0) state_next = ST_C_IN0;
            ST_C_IN0: if (cnt == '0) state_next = ST_C_G0;
            ST_C_G0:  if (cnt == '0) state_next = ST_C_W1;
            ST_C_W1:  if (cnt == '0) state_next = ST_C_IN1;
            ST_C_IN1: if (cnt == '0) state_next = ST_C_G1;
            ST_C_G1:  if (cnt == '0) state_next = ST_IDLE;
            ST_RSP:   if (rsp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase

        if (state_next != state) begin
            cnt_next = entry_load(state_next);
        end else if (cnt != '0) begin
            cnt_next = cnt - CW'(1);
        end else begin
            cnt_next = cnt;
        end
    end

    assign cal_next = cal_pins(state_next);
    assign capture  = (state == ST_RD || state == ST_VFY) && (cnt == '0);

    // Pins are decoded from the next state so they change on the accepting edge itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_q       <= OP_WRITE;
            cnt        <= '0;
            cim_a      <= '0;
            cim_d      <= '0;
            cim_wrt    <= 1'b0;
            cim_wrtbuf <= 1'b0;
            cim_read   <= 1'b0;
            cim_set    <= 1'b0;
            cim_comp   <= 1'b0;
            cim_model  <= 1'b0;
            cim_inbit  <= 1'b0;
            cim_wait_  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
        end else begin
            state      <= state_next;
            op_q       <= op_next;
            cnt        <= cnt_next;
            cim_wrt    <= (state_next == ST_WR) && (op_next == OP_WRITE);
            cim_wrtbuf <= (state_next == ST_WR) && (op_next == OP_WRITEBUF);
            cim_read   <= (state_next == ST_RD) || (state_next == ST_VFY);
            cim_set    <= cal_next.set;
            cim_comp   <= cal_next.comp;
            cim_model  <= cal_next.model;
            cim_inbit  <= cal_next.inbit;
            cim_wait_  <= cal_next.wait_;
            if (accept) begin
                if (op_e'(cmd_op) != OP_CAL) cim_a <= cmd_addr;
                if (op_e'(cmd_op) == OP_WRITE || op_e'(cmd_op) == OP_WRITEBUF) cim_d <= cmd_data;
            end
            if (capture) begin
                rsp_data  <= cim_q;
                rsp_valid <= 1'b1;
            end else if (state == ST_RSP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef CIM_HOST_WRVERIFY_EN
    // cim_d still holds the written word during VFY, so it is the reference for the compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else if (capture) begin
            rsp_err <= (state == ST_VFY) && (cim_q != cim_d);
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_cim_host_ctrl.sv
// Self-checking bench for cim_host_ctrl: table of single commands plus
// hand-written sequences for back-to-back, delayed response, CAL trace and reset.
module tb_cim_host_ctrl;
    import cim_host_pkg::*;

`ifdef CIM_HOST_WRVERIFY_EN
    localparam int VFY_EN = 1;
`else
    localparam int VFY_EN = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [8:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [8:0]  cim_a;
    logic [15:0] cim_d;
    logic [15:0] cim_q;
    logic        cim_wrt, cim_wrtbuf, cim_read, cim_set, cim_comp, cim_model, cim_inbit, cim_wait_;
    logic [15:0] q_val;

    int n_checks = 0;
    int n_fail   = 0;

    int          r_cnt [8];
    int          r_busy;
    logic        r_rsp;
    logic [15:0] r_rdata;
    logic        r_err;
    int          r_pin_bad;
    logic        r_timeout;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [8:0]  addr;
        logic [15:0] data;
        logic [15:0] qv;
        int          e_wrt, e_wrtbuf, e_read, e_set, e_comp, e_model, e_wait, e_inbit;
        int          e_busy;
        logic        e_rsp;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vecs [8];

    assign cim_q = q_val;

    cim_host_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .cim_a(cim_a), .cim_d(cim_d), .cim_q(cim_q),
        .cim_wrt(cim_wrt), .cim_wrtbuf(cim_wrtbuf), .cim_read(cim_read), .cim_set(cim_set),
        .cim_comp(cim_comp), .cim_model(cim_model), .cim_inbit(cim_inbit), .cim_wait_(cim_wait_)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one command, waits (bounded) for acceptance; returns at cycle 1 after accept.
    task automatic issueCmd(input logic [1:0] op, input logic [8:0] addr, input logic [15:0] data);
        int guard;
        cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 100) begin
            step(1);
            guard++;
        end
        if (guard == 100) checkOutput("accept_timeout", 32'd1, 32'd0);
        step(1);
        cmd_valid = 1'b0;
        cmd_addr  = ~addr;
        cmd_data  = ~data;
        cmd_op    = 2'(op + 2'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int guard;
        for (int i = 0; i < 8; i++) r_cnt[i] = 0;
        r_busy = 0; r_rsp = 1'b0; r_rdata = '0; r_err = 1'b0; r_pin_bad = 0; r_timeout = 1'b0;
        q_val = v.qv;
        rsp_ready = 1'b1;
        issueCmd(v.op, v.addr, v.data);
        for (guard = 0; guard < 200; guard++) begin
            if (cmd_ready) break;
            r_busy++;
            if (cim_wrt)    r_cnt[0]++;
            if (cim_wrtbuf) r_cnt[1]++;
            if (cim_read)   r_cnt[2]++;
            if (cim_set)    r_cnt[3]++;
            if (cim_comp)   r_cnt[4]++;
            if (cim_model)  r_cnt[5]++;
            if (cim_wait_)  r_cnt[6]++;
            if (cim_inbit)  r_cnt[7]++;
            if ((cim_wrt || cim_wrtbuf) && (cim_a !== v.addr || cim_d !== v.data)) r_pin_bad++;
            if (cim_read && cim_a !== v.addr) r_pin_bad++;
            if (rsp_valid) begin
                r_rsp = 1'b1; r_rdata = rsp_data; r_err = rsp_err;
            end
            step(1);
        end
        if (guard == 200) r_timeout = 1'b1;
    endtask

    logic [4:0]  cal_exp [13];
    logic [43:0] wrt_trace;
    logic [8:0]  a_mid;
    logic [15:0] d_mid;
    int          accepts;
    int          waited;

    initial begin
        vecs[0] = '{"wbuf_511", 2'd1, 9'd511, 16'hFFFF, 16'h0000, 0, 21, 0, 0, 0, 0, 0, 0, 21, 1'b0, 16'h0000};
        vecs[1] = '{"wr_250", 2'd0, 9'd250, 16'hFFFF, 16'hFFFF, 21, 0, 4 * VFY_EN, 0, 0, 0, 0, 0,
                    21 + 5 * VFY_EN, 1'(VFY_EN), (VFY_EN == 1) ? 16'hFFFF : 16'h0000};
        vecs[2] = '{"wr_267", 2'd0, 9'd267, 16'h0000, 16'h0000, 21, 0, 4 * VFY_EN, 0, 0, 0, 0, 0,
                    21 + 5 * VFY_EN, 1'(VFY_EN), 16'h0000};
        vecs[3] = '{"rd_12", 2'd2, 9'd12, 16'h0000, 16'hFFFC, 0, 0, 4, 0, 0, 0, 0, 0, 5, 1'b1, 16'hFFFC};
        vecs[4] = '{"rd_0", 2'd2, 9'd0, 16'h0000, 16'h1234, 0, 0, 4, 0, 0, 0, 0, 0, 5, 1'b1, 16'h1234};
        vecs[5] = '{"cal", 2'd3, 9'd0, 16'h0000, 16'h0000, 0, 0, 0, 2, 10, 5, 6, 4, 12, 1'b0, 16'h0000};
        vecs[6] = '{"wbuf_0", 2'd1, 9'd0, 16'h5A5A, 16'h0000, 0, 21, 0, 0, 0, 0, 0, 0, 21, 1'b0, 16'h0000};
        vecs[7] = '{"rd_511", 2'd2, 9'd511, 16'h0000, 16'h8001, 0, 0, 4, 0, 0, 0, 0, 0, 5, 1'b1, 16'h8001};

        cal_exp = '{5'b10000, 5'b10000, 5'b01010, 5'b01011, 5'b01011, 5'b01000, 5'b01000,
                    5'b01110, 5'b01111, 5'b01111, 5'b01100, 5'b01100, 5'b00000};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 1'b0; q_val = '0;

        #8;
        checkOutput("reset_pins", {cim_wrt, cim_wrtbuf, cim_read, cim_set, cim_comp, cim_model, cim_inbit, cim_wait_}, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_data", rsp_data, 0);
        checkOutput("reset_rsp_err", rsp_err, 0);
        checkOutput("reset_cim_a", cim_a, 0);
        #4 rst_n = 1'b1;
        step(1);
        checkOutput("reset_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            checkOutput({vecs[i].name, "_wrt"},    r_cnt[0], vecs[i].e_wrt);
            checkOutput({vecs[i].name, "_wrtbuf"}, r_cnt[1], vecs[i].e_wrtbuf);
            checkOutput({vecs[i].name, "_read"},   r_cnt[2], vecs[i].e_read);
            checkOutput({vecs[i].name, "_set"},    r_cnt[3], vecs[i].e_set);
            checkOutput({vecs[i].name, "_comp"},   r_cnt[4], vecs[i].e_comp);
            checkOutput({vecs[i].name, "_model"},  r_cnt[5], vecs[i].e_model);
            checkOutput({vecs[i].name, "_wait"},   r_cnt[6], vecs[i].e_wait);
            checkOutput({vecs[i].name, "_inbit"},  r_cnt[7], vecs[i].e_inbit);
            checkOutput({vecs[i].name, "_busy"},   r_busy, vecs[i].e_busy);
            checkOutput({vecs[i].name, "_rsp"},    r_rsp, vecs[i].e_rsp);
            checkOutput({vecs[i].name, "_rdata"},  r_rdata, vecs[i].e_rdata);
            checkOutput({vecs[i].name, "_err"},    r_err, 0);
            checkOutput({vecs[i].name, "_addr_data"}, r_pin_bad, 0);
            checkOutput({vecs[i].name, "_timeout"}, r_timeout, 0);
            checkOutput({vecs[i].name, "_idle_pins"},
                        {cim_wrt, cim_wrtbuf, cim_read, cim_set, cim_comp, cim_model, cim_inbit, cim_wait_}, 0);
        end

`ifndef CIM_HOST_WRVERIFY_EN
        // Back-to-back writes with cmd_valid held through the busy window.
        step(1);
        cmd_op = 2'd0; cmd_addr = 9'd250; cmd_data = 16'hFFFF; cmd_valid = 1'b1;
        accepts = 0; wrt_trace = '0; a_mid = '0; d_mid = '0;
        for (int c = 0; c < 44; c++) begin
            if (cmd_valid && cmd_ready) accepts++;
            step(1);
            wrt_trace[c] = cim_wrt;
            if (c == 0) begin cmd_addr = 9'd267; cmd_data = 16'h0000; end
            if (c == 30) begin a_mid = cim_a; d_mid = cim_d; end
            if (accepts == 2) cmd_valid = 1'b0;
        end
        checkOutput("b2b_accepts", accepts, 2);
        checkOutput("b2b_wrt_total", $countones(wrt_trace), 42);
        checkOutput("b2b_first_end", wrt_trace[20], 1);
        checkOutput("b2b_gap", wrt_trace[21], 0);
        checkOutput("b2b_second_start", wrt_trace[22], 1);
        checkOutput("b2b_second_end", {wrt_trace[43], wrt_trace[42]}, 2'b01);
        checkOutput("b2b_addr2", a_mid, 9'd267);
        checkOutput("b2b_data2", d_mid, 16'h0000);
`endif

        // READ with rsp_ready held off for three cycles after rsp_valid rises.
        step(1);
        q_val = 16'hFFFC; rsp_ready = 1'b0;
        issueCmd(2'd2, 9'd12, 16'h0);
        checkOutput("rd_hold_read_c1", cim_read, 1);
        step(3);
        checkOutput("rd_hold_c4_read", cim_read, 1);
        checkOutput("rd_hold_c4_valid", rsp_valid, 0);
        step(1);
        checkOutput("rd_hold_c5_valid", rsp_valid, 1);
        checkOutput("rd_hold_c5_data", rsp_data, 16'hFFFC);
        checkOutput("rd_hold_c5_read", cim_read, 0);
        q_val = 16'h0000;
        step(3);
        checkOutput("rd_hold_c8_valid", rsp_valid, 1);
        checkOutput("rd_hold_c8_data", rsp_data, 16'hFFFC);
        checkOutput("rd_hold_c8_ready", cmd_ready, 0);
        rsp_ready = 1'b1;
        step(1);
        checkOutput("rd_hold_done_valid", rsp_valid, 0);
        checkOutput("rd_hold_done_ready", cmd_ready, 1);

        // Per-cycle CAL trace.
        issueCmd(2'd3, 9'd0, 16'h0);
        for (int c = 0; c < 13; c++) begin
            checkOutput($sformatf("cal_trace_c%0d", c + 1),
                        {cim_set, cim_comp, cim_model, cim_wait_, cim_inbit}, cal_exp[c]);
            step(1);
        end

        // Asynchronous reset in the middle of C_IN0.
        issueCmd(2'd3, 9'd0, 16'h0);
        step(3);
        checkOutput("rst_mid_inbit", cim_inbit, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_pins", {cim_wrt, cim_wrtbuf, cim_read, cim_set, cim_comp, cim_model, cim_inbit, cim_wait_}, 0);
        checkOutput("rst_mid_rsp_valid", rsp_valid, 0);
        #2 rst_n = 1'b1;
        step(1);
        checkOutput("rst_after_ready", cmd_ready, 1);
        checkOutput("rst_after_rsp_valid", rsp_valid, 0);
        checkOutput("rst_after_pins", {cim_set, cim_comp, cim_model, cim_inbit, cim_wait_}, 0);

`ifdef CIM_HOST_WRVERIFY_EN
        // Verify readback with a mismatching and then a matching model.
        rsp_ready = 1'b0; q_val = 16'd2343;
        issueCmd(2'd0, 9'd299, 16'd2342);
        waited = 1;
        while (!rsp_valid && waited < 60) begin step(1); waited++; end
        checkOutput("vfy_bad_latency", waited, 26);
        checkOutput("vfy_bad_err", rsp_err, 1);
        checkOutput("vfy_bad_data", rsp_data, 16'd2343);
        rsp_ready = 1'b1;
        step(1);
        checkOutput("vfy_bad_cleared", rsp_valid, 0);
        rsp_ready = 1'b0; q_val = 16'd2342;
        issueCmd(2'd0, 9'd299, 16'd2342);
        waited = 1;
        while (!rsp_valid && waited < 60) begin step(1); waited++; end
        checkOutput("vfy_ok_latency", waited, 26);
        checkOutput("vfy_ok_err", rsp_err, 0);
        checkOutput("vfy_ok_data", rsp_data, 16'd2342);
        rsp_ready = 1'b1;
        step(1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cim_host_ctrl.md
# cim_host_ctrl

Synthesizable host-side sequencer that drives the SRAM_CIM macro pin interface: address/data, weight and buffer writes, reads, and the set/compute/model/inbit/wait_ calibration-compute sequence. It accepts commands over a valid/ready port and expands each one into a cycle-exact pin sequence. It returns read data over a valid/ready response port. It sits between the system controller and the SRAM_CIM instance and replaces hand-driven pin stimulus in silicon.

## Interface
- WR_CYCLES, 21: cycles wrt/wrtbuf is held per write; must be ≥1
- RD_CYCLES, 4: cycles read is held; q is sampled on the last cycle; must be ≥1
- clk  in  1  clock (rising edge)
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE with no pending response
- cmd_op  in  2  0=WRITE (array), 1=WRITEBUF, 2=READ, 3=CAL
- cmd_addr  in  9  target address
- cmd_data  in  16  write data
- rsp_valid  out  1  read or verify result available; held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_data  out  16  captured cim_q
- rsp_err  out  1  verify mismatch (macro-enabled only, else 0)
- cim_a  out  9  to SRAM_CIM a
- cim_d  out  16  to SRAM_CIM d
- cim_q  in  16  from SRAM_CIM q
- cim_wrt, cim_wrtbuf, cim_read, cim_set, cim_comp, cim_model, cim_inbit, cim_wait_  out  1 each  SRAM_CIM controls

## Operation
- Reset (async, any state): state=IDLE, counter=0, every cim_* output=0, rsp_valid=0, rsp_data=0, rsp_err=0. cmd_ready=1 once rst_n is high.
- Accept on cmd_valid&&cmd_ready. Op, addr, and data are latched, so later changes to cmd_* are ignored.
- WRITE/WRITEBUF: cim_a=addr, cim_d=data. cim_wrt (op 0) or cim_wrtbuf (op 1) is high for exactly WR_CYCLES. All other controls stay 0. Then IDLE. No response.
- READ: cim_a=addr, cim_read=1 for RD_CYCLES. cim_q is captured into rsp_data on the last read cycle. rsp_valid=1 on the following cycle, then state RSP.
- CAL: a fixed 12-cycle schedule.
  - S_SET: set=1 (2 cycles).
  - C_W0: comp=1, model=0, wait_=1, inbit=0 (1 cycle).
  - C_IN0: inbit=1 (2 cycles).
  - C_G0: inbit=0, wait_=0 (2 cycles).
  - C_W1: model=1, wait_=1 (1 cycle).
  - C_IN1: inbit=1 (2 cycles).
  - C_G1: inbit=0, wait_=0 (2 cycles).
  - End: comp and model drop to 0 on the cycle returning to IDLE. No response.
- States: IDLE, WR, RD, S_SET, C_W0, C_IN0, C_G0, C_W1, C_IN1, C_G1, VFY (macro only), RSP.
- RSP: hold rsp_valid/rsp_data/rsp_err until rsp_ready. On the handshake cycle, clear rsp_valid and go to IDLE.
- cim_a/cim_d keep their last driven value outside WR/RD/VFY.

## Timing
- All cim_* outputs are registered. Pins change on the first edge after accept.
- A state's pins are valid for exactly its cycle count, measured in edges.
- Command-to-command gaps: WRITE→next accept ≥ WR_CYCLES+1 cycles. CAL→next accept = 13 cycles.
- Read latency: accept → rsp_valid = RD_CYCLES+1 cycles.
- cmd_valid while busy is not accepted (cmd_ready=0). It is not an error and is not queued.
- If rsp_ready is already high when rsp_valid rises, the response completes in 1 cycle.
- Counter width is $clog2(max(WR_CYCLES,RD_CYCLES)+1). The counter reloads on every state entry and never wraps.

## Configuration
- CIM_HOST_WRVERIFY_EN
  - Defined: after an op-0 WRITE, the block enters VFY. VFY does a RD_CYCLES read of the same address and compares cim_q to the written data. It returns rsp_valid with rsp_data=cim_q and rsp_err=(cim_q!=data).
  - Undefined: the VFY state is absent, WRITE produces no response, and rsp_err is tied 0.
- WRITEBUF is never verified.

## Structure
- Package cim_host_pkg holds:
  - op enum (OP_WRITE, OP_WRITEBUF, OP_READ, OP_CAL)
  - state enum
  - CAL phase length constants (2,1,2,2,1,2,2)
  - address/data width constants (9, 16)
- Single module with no sub-module. The pin-drive decode is a registered function of next-state inside the module.

## Test plan
- WRITEBUF addr 511 data 0xFFFF → cim_wrtbuf high exactly 21 cycles with cim_a=511, cim_d=0xFFFF; cim_wrt=0 throughout; cmd_ready low for the same 21 cycles.
- WRITE 250/0xFFFF then 267/0x0000 back-to-back, with cmd_valid held during busy → only two accepts; cim_wrt pulses of 21 cycles each, separated by one idle cycle.
- READ addr 12, with the bench model returning cim_q=0xFFFC → cim_read high 4 cycles; rsp_valid on cycle 5 with rsp_data=0xFFFC. rsp_ready delayed 3 cycles → data held stable.
- CAL → per-cycle pin trace {set,comp,model,wait_,inbit} matches the 12-cycle schedule; all five are 0 on cycle 13.
- rst_n asserted mid-C_IN0 → all cim_* go to 0 asynchronously; after release, IDLE with cmd_ready=1 and no rsp_valid.
- Macro defined, WRITE 299/2342 with the model returning 2343 on readback → rsp_valid, rsp_err=1, rsp_data=2343. With a matching model → rsp_err=0.
